// File: rtl/run_decimator_checker.sv
// Aligns to a run-repeated counter stream, checks run length and increment,
// and emits one decimated strobe per completed run once locked.
module run_decimator_checker #(
  parameter int W         = 2,
  parameter int RUN       = 3,
  parameter int LOCK_RUNS = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_val,
  output logic                 locked,
  output logic                 value_strobe,
  output logic [W-1:0]         value_out,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int RC_W = 4;
  localparam int GR_W = (LOCK_RUNS > 1) ? $clog2(LOCK_RUNS + 1) : 1;

  localparam logic [RC_W-1:0]      RUN_L   = RC_W'(RUN);
  localparam logic [RC_W-1:0]      RUN_M1  = RC_W'(RUN - 1);
  localparam logic [RC_W-1:0]      RC_ONE  = RC_W'(1);
  localparam logic [GR_W-1:0]      GR_LAST = GR_W'(LOCK_RUNS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  state_t          state;
  logic [W-1:0]    prev;
  logic            prev_valid;
  logic [W-1:0]    cur_val;
  logic [RC_W-1:0] run_cnt;
  logic [GR_W-1:0] good_runs;

  logic [W-1:0] next_val;
  logic         in_run;
  logic         match;
  logic         completes;

  // Inside a run the sample must repeat; at a run end it must step by one (mod 2^W).
  assign next_val  = cur_val + 1'b1;
  assign in_run    = (run_cnt < RUN_L);
  assign match     = in_run ? (in_val == cur_val) : (in_val == next_val);
  assign completes = in_run && match && (run_cnt == RUN_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HUNT;
      prev         <= '0;
      prev_valid   <= 1'b0;
      cur_val      <= '0;
      run_cnt      <= RC_ONE;
      good_runs    <= '0;
      locked       <= 1'b0;
      value_strobe <= 1'b0;
      value_out    <= '0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
    end else begin
      value_strobe <= 1'b0;
      err_pulse    <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (!prev_valid) begin
              prev       <= in_val;
              prev_valid <= 1'b1;
            end else if (in_val != prev) begin
              // A value change marks the start of a fresh run.
              cur_val   <= in_val;
              run_cnt   <= RC_ONE;
              good_runs <= '0;
              state     <= SYNC;
            end
          end
          SYNC, LOCK: begin
            if (!match) begin
              state      <= HUNT;
              prev       <= in_val;
              prev_valid <= 1'b1;
              locked     <= 1'b0;
              if (state == LOCK) begin
                err_pulse <= 1'b1;
                if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
              end
            end else if (in_run) begin
              run_cnt <= run_cnt + 1'b1;
              if (completes) begin
                if (state == LOCK) begin
                  value_strobe <= 1'b1;
                  value_out    <= cur_val;
                end else if (good_runs == GR_LAST) begin
                  // The run that satisfies the lock criterion is also reported.
                  state        <= LOCK;
                  locked       <= 1'b1;
                  value_strobe <= 1'b1;
                  value_out    <= cur_val;
                end else begin
                  good_runs <= good_runs + 1'b1;
                end
              end
            end else begin
              cur_val <= in_val;
              run_cnt <= RC_ONE;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
